cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
Multi-cycle control sequencer for the 16-bit CPU core. It generates the FETCH/EXEC1/EXEC2 timing strobes that drive the ALU, register file, PC and memory interface.
- Its exec1 output is the timing signal consumed by the ALU.
- It applies SKIP-flag discard, handles memory wait states with a timeout, and counts retired instructions.

Parameters:
WAIT_MAX, 15, memory-wait cycles tolerated in FETCH or EXEC2 before a bus error (1..255)
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
ir  input  16  instruction register contents; valid from EXEC1 onward
mem_ready  input  1  memory handshake; a transfer completes in a cycle where mem_ready=1
skip_q  input  1  Q output of the SKIP flip-flop
cond_true  input  1  jump condition result from the condition unit
run  input  1  level; leaves HALTED when high
fetch  output  1  high in FETCH state
exec1  output  1  high in EXEC1 state (ALU/register timing)
exec2  output  1  high in EXEC2 state
ir_en  output  1  load IR from memory data
pc_inc  output  1  increment PC
pc_load  output  1  load PC with jump target
mem_rd  output  1  memory read request
mem_wr  output  1  memory write request
skip_clr  output  1  clear SKIP flip-flop
halted  output  1  high in HALTED state
bus_err  output  1  sticky timeout flag
retired  output  CNT_W  retired-instruction count

Behaviour:
- States: HALTED, FETCH, EXEC1, EXEC2. State-decoded outputs are Moore; the handshake-qualified strobes are Mealy.
- Reset (async): state=HALTED, retired=0, bus_err=0, wait counter=0. halted=1; every other output is 0.
- Instruction decode on ir[15:12]:
  - 11xx: ARM (ALU register op)
  - 0xxx: immediate op
  - 1000: LDR
  - 1010: STR
  - 1001: JMP
  - 1011: HALT
  - 1100..1111 are ARM; no overlap with the other classes.
- HALTED: all strobes 0. run=1 -> FETCH next cycle, and bus_err clears on that transition.
- FETCH: mem_rd=1.
  - mem_ready=0: stay and increment the wait counter.
  - mem_ready=1 and skip_q=1: pc_inc=1, skip_clr=1, ir_en=0; stay in FETCH. The instruction is discarded and not counted.
  - mem_ready=1 and skip_q=0: ir_en=1, pc_inc=1 -> EXEC1.
- EXEC1 is exactly one cycle.
  - ARM or immediate: -> FETCH, retired+1.
  - JMP: pc_load=cond_true -> FETCH, retired+1.
  - LDR/STR: -> EXEC2.
  - HALT: -> HALTED, retired+1.
- EXEC2: mem_rd=1 for LDR, mem_wr=1 for STR; held until mem_ready=1, then -> FETCH, retired+1.
- Wait counter:
  - Clears on every state change and on any completed handshake.
  - When it reaches WAIT_MAX with mem_ready still 0: bus_err<=1 and state -> HALTED next cycle; the pending request drops.
  - mem_ready=1 in the cycle the counter equals WAIT_MAX completes the handshake normally; no error is raised.
- retired wraps from 2^CNT_W-1 to 0 with no flag.
- run is ignored outside HALTED.
- skip_q is sampled only in FETCH with mem_ready=1.
- Latency: an ARM or immediate instruction with zero-wait memory takes 2 cycles; LDR/STR take 3.
- Reset asserted mid-instruction aborts immediately: outputs go to reset values in the same cycle, so no mem_wr glitch extends past the reset assertion.

Decomposition:
- Package cpu_seq_pkg: state enum (HALTED/FETCH/EXEC1/EXEC2), opcode-class constants (OPC_LDR=4'b1000, OPC_JMP=4'b1001, OPC_STR=4'b1010, OPC_HALT=4'b1011), decode function is_arm(ir).
- One sub-module, seq_wait_timer: wait counter with clear/enable inputs and an expired output, parameterised by WAIT_MAX.

Test Plan:
1. Reset, run=1 pulse, mem_ready=1, ir=16'hC0A0 (ARM) -> fetch at cycle 1, exec1 at cycle 2, fetch at cycle 3; retired=1; wenout path sees exactly one exec1 cycle.
2. ir=16'h8123 (LDR) with mem_ready low for 3 cycles in EXEC2 -> mem_rd held 4 cycles; retired increments only on the ready cycle; total 6 cycles to the next fetch.
3. skip_q=1 at FETCH with mem_ready=1 -> skip_clr=1, pc_inc=1, ir_en=0, stays in FETCH; retired unchanged.
4. ir=16'h9xxx (JMP), once with cond_true=1 and once with 0 -> pc_load=1 only in the EXEC1 of the first case.
5. mem_ready held 0 in FETCH with WAIT_MAX=15 -> bus_err=1 and halted=1 after 16 cycles. A following run=1 clears bus_err and re-enters FETCH. With mem_ready=1 on exactly the 16th cycle (counter=WAIT_MAX), the handshake completes normally and bus_err stays 0.
6. Assert reset during EXEC2 of a STR (mem_wr=1) -> mem_wr=0 and halted=1 in the same cycle. Preload retired near 16'hFFFF via execution -> wraps to 16'h0000.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared types and opcode decode for the multi-cycle control sequencer.
package cpu_seq_pkg;

   typedef enum logic [1:0] {
      ST_HALTED = 2'd0,
      ST_FETCH  = 2'd1,
      ST_EXEC1  = 2'd2,
      ST_EXEC2  = 2'd3
   } state_e;

   // Opcode classes on ir[15:12]; 0xxx is immediate, 11xx is ARM.
   localparam logic [3:0] OPC_LDR  = 4'b1000;
   localparam logic [3:0] OPC_JMP  = 4'b1001;
   localparam logic [3:0] OPC_STR  = 4'b1010;
   localparam logic [3:0] OPC_HALT = 4'b1011;

   // ARM register ops occupy the whole 1100..1111 range.
   function automatic logic is_arm(input logic [3:0] opc);
      return (opc >= 4'b1100);
   endfunction

   // LDR and STR are the only classes that need the EXEC2 bus cycle.
   function automatic logic is_mem_op(input logic [3:0] opc);
      return (opc == OPC_LDR) || (opc == OPC_STR);
   endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Memory wait-state counter; flags expiry once WAIT_MAX wait cycles have elapsed.
module seq_wait_timer #(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned W = $clog2(WAIT_MAX + 1);

   logic [W-1:0] cnt_q;

   // Count wait cycles; clear wins, and the count holds once it reaches WAIT_MAX.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && !expired_o) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired_o = (cnt_q == W'(WAIT_MAX));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: FETCH/EXEC1/EXEC2 strobes, SKIP discard,
// memory wait timeout and retired-instruction count for the 16-bit core.
module cpu_sequencer
   import cpu_seq_pkg::*;
#(
   parameter int unsigned WAIT_MAX = 15,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [15:0]      ir,
   input  logic             mem_ready,
   input  logic             skip_q,
   input  logic             cond_true,
   input  logic             run,
   output logic             fetch,
   output logic             exec1,
   output logic             exec2,
   output logic             ir_en,
   output logic             pc_inc,
   output logic             pc_load,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             skip_clr,
   output logic             halted,
   output logic             bus_err,
   output logic [CNT_W-1:0] retired
);

   state_e           state_q;
   logic             bus_err_q;
   logic [CNT_W-1:0] retired_q;

   logic [3:0] opc;
   logic       op_mem;
   logic       mem_phase;
   logic       handshake;
   logic       timeout;
   logic       retire;
   logic       wait_clr;
   logic       wait_en;
   logic       wait_expired;
   logic       unused_ir_bits;

   assign opc            = ir[15:12];
   assign op_mem         = is_mem_op(opc);
   assign unused_ir_bits = ^ir[11:0];

   // FETCH and EXEC2 are the only states that wait on the memory handshake.
   assign mem_phase = (state_q == ST_FETCH) || (state_q == ST_EXEC2);
   assign handshake = mem_phase && mem_ready;
   assign timeout   = mem_phase && !mem_ready && wait_expired;

   // The counter is zero on entry to every state: HALTED and EXEC1 always hold
   // it clear, and every exit from FETCH/EXEC2 is a handshake or a timeout.
   assign wait_clr = handshake || timeout ||
                     (state_q == ST_HALTED) || (state_q == ST_EXEC1);
   assign wait_en  = mem_phase && !mem_ready;

   // Non-memory ops retire in EXEC1; LDR/STR retire when EXEC2 completes.
   assign retire = ((state_q == ST_EXEC1) && !op_mem) ||
                   ((state_q == ST_EXEC2) && mem_ready);

   seq_wait_timer #(
      .WAIT_MAX (WAIT_MAX)
   ) u_wait_timer (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (wait_clr),
      .en_i      (wait_en),
      .expired_o (wait_expired)
   );

   // Sequencer state, sticky bus-error flag and retired counter.
   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_HALTED;
         bus_err_q <= 1'b0;
         retired_q <= '0;
      end else begin
         if (retire) begin
            retired_q <= retired_q + 1'b1;
         end
         unique case (state_q)
            ST_HALTED: begin
               if (run) begin
                  state_q   <= ST_FETCH;
                  bus_err_q <= 1'b0;
               end
            end
            ST_FETCH: begin
               if (timeout) begin
                  state_q   <= ST_HALTED;
                  bus_err_q <= 1'b1;
               end else if (mem_ready && !skip_q) begin
                  state_q <= ST_EXEC1;
               end
            end
            ST_EXEC1: begin
               if (op_mem) begin
                  state_q <= ST_EXEC2;
               end else if (opc == OPC_HALT) begin
                  state_q <= ST_HALTED;
               end else begin
                  state_q <= ST_FETCH;
               end
            end
            ST_EXEC2: begin
               if (mem_ready) begin
                  state_q <= ST_FETCH;
               end else if (timeout) begin
                  state_q   <= ST_HALTED;
                  bus_err_q <= 1'b1;
               end
            end
            default: state_q <= ST_HALTED;
         endcase
      end
   end

   // Handshake-qualified strobes decoded from the current state and inputs.
   // NOTE: every output is given a default before the case so no latch is inferred.
   always_comb begin
      ir_en    = 1'b0;
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      skip_clr = 1'b0;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      unique case (state_q)
         ST_FETCH: begin
            mem_rd = 1'b1;
            if (mem_ready) begin
               pc_inc   = 1'b1;
               skip_clr = skip_q;
               ir_en    = !skip_q;
            end
         end
         ST_EXEC1: begin
            pc_load = (opc == OPC_JMP) && cond_true;
         end
         ST_EXEC2: begin
            mem_rd = (opc == OPC_LDR);
            mem_wr = (opc == OPC_STR);
         end
         default: ;
      endcase
   end

   assign fetch   = (state_q == ST_FETCH);
   assign exec1   = (state_q == ST_EXEC1);
   assign exec2   = (state_q == ST_EXEC2);
   assign halted  = (state_q == ST_HALTED);
   assign bus_err = bus_err_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: a cycle model pushes expected outputs
// into a scoreboard as each cycle's inputs are driven; they are popped and
// compared on the following falling edge.
module tb_cpu_sequencer;

   localparam int unsigned WAIT_MAX = 15;
   // Narrow counter so the wrap from all-ones to zero is reachable quickly.
   localparam int unsigned CNT_W    = 8;

   localparam logic [15:0] IR_ARM = 16'hC0A0;
   localparam logic [15:0] IR_LDR = 16'h8123;
   localparam logic [15:0] IR_STR = 16'hA456;
   localparam logic [15:0] IR_JMP = 16'h9ABC;

   localparam int M_H = 0, M_F = 1, M_E1 = 2, M_E2 = 3;

   logic             clk;
   logic             reset;
   logic [15:0]      ir;
   logic             mem_ready, skip_q, cond_true, run;
   logic             fetch, exec1, exec2, ir_en, pc_inc, pc_load;
   logic             mem_rd, mem_wr, skip_clr, halted, bus_err;
   logic [CNT_W-1:0] retired;

   cpu_sequencer #(
      .WAIT_MAX (WAIT_MAX),
      .CNT_W    (CNT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ir        (ir),
      .mem_ready (mem_ready),
      .skip_q    (skip_q),
      .cond_true (cond_true),
      .run       (run),
      .fetch     (fetch),
      .exec1     (exec1),
      .exec2     (exec2),
      .ir_en     (ir_en),
      .pc_inc    (pc_inc),
      .pc_load   (pc_load),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .skip_clr  (skip_clr),
      .halted    (halted),
      .bus_err   (bus_err),
      .retired   (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic             fetch, exec1, exec2, ir_en, pc_inc, pc_load;
      logic             mem_rd, mem_wr, skip_clr, halted, bus_err;
      logic [CNT_W-1:0] retired;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   int               m_st;
   int               m_wait;
   logic [CNT_W-1:0] m_ret;
   logic             m_berr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic model_reset();
      m_st   = M_H;
      m_wait = 0;
      m_ret  = '0;
      m_berr = 1'b0;
      sb_q.delete();
   endtask

   // Expected outputs for the cycle whose inputs were just driven, then advance.
   task automatic model_step();
      exp_t       e;
      int         nst;
      logic [3:0] op;
      e         = '0;
      op        = ir[15:12];
      e.fetch   = (m_st == M_F);
      e.exec1   = (m_st == M_E1);
      e.exec2   = (m_st == M_E2);
      e.halted  = (m_st == M_H);
      e.bus_err = m_berr;
      e.retired = m_ret;
      nst       = m_st;
      case (m_st)
         M_H: if (run) begin nst = M_F; m_berr = 1'b0; end
         M_F: begin
            e.mem_rd = 1'b1;
            if (mem_ready) begin
               e.pc_inc = 1'b1;
               if (skip_q) begin e.skip_clr = 1'b1; m_wait = 0; end
               else begin e.ir_en = 1'b1; nst = M_E1; end
            end else if (m_wait == WAIT_MAX) begin
               m_berr = 1'b1; nst = M_H;
            end else m_wait++;
         end
         M_E1: begin
            if (op == 4'b1000 || op == 4'b1010) nst = M_E2;
            else begin
               m_ret = m_ret + 1'b1;
               if (op == 4'b1001) e.pc_load = cond_true;
               nst = (op == 4'b1011) ? M_H : M_F;
            end
         end
         default: begin
            e.mem_rd = (op == 4'b1000);
            e.mem_wr = (op == 4'b1010);
            if (mem_ready) begin m_ret = m_ret + 1'b1; nst = M_F; end
            else if (m_wait == WAIT_MAX) begin m_berr = 1'b1; nst = M_H; end
            else m_wait++;
         end
      endcase
      if (nst != m_st) m_wait = 0;
      m_st = nst;
      sb_q.push_back(e);
   endtask

   task automatic compare_out();
      exp_t e;
      check($sformatf("c%0d sb_depth", cyc), sb_q.size(), 1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check($sformatf("c%0d fetch", cyc),    fetch,    e.fetch);
         check($sformatf("c%0d exec1", cyc),    exec1,    e.exec1);
         check($sformatf("c%0d exec2", cyc),    exec2,    e.exec2);
         check($sformatf("c%0d ir_en", cyc),    ir_en,    e.ir_en);
         check($sformatf("c%0d pc_inc", cyc),   pc_inc,   e.pc_inc);
         check($sformatf("c%0d pc_load", cyc),  pc_load,  e.pc_load);
         check($sformatf("c%0d mem_rd", cyc),   mem_rd,   e.mem_rd);
         check($sformatf("c%0d mem_wr", cyc),   mem_wr,   e.mem_wr);
         check($sformatf("c%0d skip_clr", cyc), skip_clr, e.skip_clr);
         check($sformatf("c%0d halted", cyc),   halted,   e.halted);
         check($sformatf("c%0d bus_err", cyc),  bus_err,  e.bus_err);
         check($sformatf("c%0d retired", cyc),  retired,  e.retired);
      end
   endtask

   // One clock: drive inputs just after the rising edge, compare on the falling edge.
   task automatic cycle(input logic [15:0] ir_v, input logic rdy, input logic skp,
                        input logic cnd, input logic rn);
      @(posedge clk);
      #1;
      ir = ir_v; mem_ready = rdy; skip_q = skp; cond_true = cnd; run = rn;
      cyc++;
      model_step();
      @(negedge clk);
      compare_out();
   endtask

   // Assert reset wherever we are; outputs must take reset values at once.
   task automatic reset_dut(input string tag);
      reset = 1'b1;
      model_reset();
      #1;
      check({tag, " halted"},   halted,   1'b1);
      check({tag, " fetch"},    fetch,    1'b0);
      check({tag, " exec1"},    exec1,    1'b0);
      check({tag, " exec2"},    exec2,    1'b0);
      check({tag, " mem_rd"},   mem_rd,   1'b0);
      check({tag, " mem_wr"},   mem_wr,   1'b0);
      check({tag, " ir_en"},    ir_en,    1'b0);
      check({tag, " pc_inc"},   pc_inc,   1'b0);
      check({tag, " skip_clr"}, skip_clr, 1'b0);
      check({tag, " bus_err"},  bus_err,  1'b0);
      check({tag, " retired"},  retired,  0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_ex1, n_rd, n_fetch, guard;
      ir = '0; mem_ready = 1'b0; skip_q = 1'b0; cond_true = 1'b0; run = 1'b0;
      reset_dut("rst0");

      // T1: ARM with zero-wait memory, two cycles FETCH->EXEC1->FETCH.
      cycle(IR_ARM, 1'b1, 1'b0, 1'b0, 1'b1);
      n_ex1 = 0;
      cycle(IR_ARM, 1'b1, 1'b0, 1'b0, 1'b0); check("t1_c1_fetch", fetch, 1'b1); n_ex1 += int'(exec1);
      cycle(IR_ARM, 1'b1, 1'b0, 1'b0, 1'b0); check("t1_c2_exec1", exec1, 1'b1); n_ex1 += int'(exec1);
      cycle(IR_ARM, 1'b1, 1'b0, 1'b0, 1'b0); check("t1_c3_fetch", fetch, 1'b1); n_ex1 += int'(exec1);
      check("t1_retired", retired, 1);
      check("t1_exec1_count", n_ex1, 1);
      cycle(IR_ARM, 1'b0, 1'b0, 1'b0, 1'b0); // EXEC1 of the second ARM

      // T2: LDR with three wait cycles in EXEC2.
      n_rd = 0;
      foreach (IR_LDR[i]) ; // no-op keeps loop variable scoping simple
      begin
         logic rdy_tab [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
         for (int i = 0; i < 6; i++) begin
            cycle(IR_LDR, rdy_tab[i], 1'b0, 1'b0, 1'b0);
            if (exec2 && mem_rd) n_rd++;
            if (i == 4) check("t2_retired_waiting", retired, 2);
         end
      end
      check("t2_exec2_rd_cycles", n_rd, 4);
      cycle(IR_ARM, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t2_next_fetch", fetch, 1'b1);
      check("t2_retired", retired, 3);

      // T3: SKIP discard stays in FETCH and does not retire.
      cycle(IR_ARM, 1'b1, 1'b1, 1'b0, 1'b0);
      check("t3_skip_clr", skip_clr, 1'b1);
      check("t3_pc_inc", pc_inc, 1'b1);
      check("t3_ir_en", ir_en, 1'b0);
      cycle(IR_ARM, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t3_still_fetch", fetch, 1'b1);
      check("t3_retired", retired, 3);

      // T4: JMP taken then not taken.
      cycle(IR_JMP, 1'b1, 1'b0, 1'b1, 1'b0);
      cycle(IR_JMP, 1'b0, 1'b0, 1'b1, 1'b0);
      check("t4_taken_pc_load", pc_load, 1'b1);
      cycle(IR_JMP, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(IR_JMP, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t4_not_taken_pc_load", pc_load, 1'b0);
      check("t4_exec1", exec1, 1'b1);

      // T5: FETCH timeout, recovery via run, and a handshake exactly at WAIT_MAX.
      reset_dut("rst5");
      cycle(IR_ARM, 1'b0, 1'b0, 1'b0, 1'b1);
      n_fetch = 0; guard = 0;
      do begin
         cycle(IR_ARM, 1'b0, 1'b0, 1'b0, 1'b0);
         if (fetch) n_fetch++;
         guard++;
      end while (!halted && guard < 40);
      check("t5_wait_cycles", n_fetch, WAIT_MAX + 1);
      check("t5_bus_err", bus_err, 1'b1);
      check("t5_halted", halted, 1'b1);
      cycle(IR_ARM, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t5_bus_err_held_in_halted", bus_err, 1'b1);
      cycle(IR_ARM, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t5_rerun_fetch", fetch, 1'b1);
      check("t5_bus_err_cleared", bus_err, 1'b0);
      for (int i = 0; i < 14; i++) cycle(IR_ARM, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(IR_ARM, 1'b1, 1'b0, 1'b0, 1'b0);
      check("t5_edge_fetch", fetch, 1'b1);
      cycle(IR_ARM, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t5_edge_exec1", exec1, 1'b1);
      check("t5_edge_no_err", bus_err, 1'b0);

      // T6: reset during a STR in EXEC2 drops mem_wr immediately.
      reset_dut("rst6a");
      cycle(IR_STR, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(IR_STR, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(IR_STR, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(IR_STR, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t6_mem_wr_before", mem_wr, 1'b1);
      reset_dut("t6_abort");

      // Retired counter wraps from all-ones to zero.
      cycle(IR_ARM, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
         cycle(IR_ARM, 1'b1, 1'b0, 1'b0, 1'b0);
         cycle(IR_ARM, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      cycle(IR_ARM, 1'b1, 1'b0, 1'b0, 1'b0);
      check("wrap_all_ones", retired, (1 << CNT_W) - 1);
      cycle(IR_ARM, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(IR_ARM, 1'b1, 1'b0, 1'b0, 1'b0);
      check("wrap_zero", retired, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
